// File: rtl/uart_tx_serializer.sv
// UART transmitter: synchronises the divided baud clock into a one-cycle bit
// tick and shifts parallel words out LSB-first as start/data/parity/stop bits.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  baud_clk_in,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_valid_in,
  output logic                  tx_ready_out,
  output logic                  tx_out,
  output logic                  busy_out
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam int unsigned STOP_W = 2;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);
  localparam logic PARITY_INV = (PARITY_ODD != 0);
  localparam logic HAS_PARITY = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // Baud clock synchroniser and rising-edge detector
  logic sync_q1;
  logic sync_q2;
  logic delay_q;
  logic tick_c;

  state_e              state_q,    state_d;
  logic [DATA_WIDTH-1:0] shift_q,  shift_d;
  logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [STOP_W-1:0]   stop_cnt_q, stop_cnt_d;
  logic                parity_q,   parity_d;
  logic                tx_q,       tx_d;
  logic                busy_q,     busy_d;
  logic                ready_q,    ready_d;

  // Two-flop synchroniser plus one delay flop for edge detection
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      delay_q <= 1'b0;
    end else begin
      sync_q1 <= baud_clk_in;
      sync_q2 <= sync_q1;
      delay_q <= sync_q2;
    end
  end

  assign tick_c = sync_q2 & ~delay_q;

  // Frame state register
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state and registered-output logic; every transition after IDLE waits for a tick
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    ready_d    = ready_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        // A tick coinciding with the transfer is deliberately ignored here
        if (tx_valid_in && ready_q) begin
          shift_d  = tx_data_in;
          parity_d = (^tx_data_in) ^ PARITY_INV;
          state_d  = S_WAIT;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
        end
      end

      S_WAIT: begin
        if (tick_c) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (tick_c) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end

      S_DATA: begin
        if (tick_c) begin
          if (bit_cnt_q != LAST_BIT) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            tx_d      = shift_q[1];
          end else if (HAS_PARITY) begin
            state_d = S_PARITY;
            tx_d    = parity_q;
          end else begin
            state_d    = S_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = '0;
          end
        end
      end

      S_PARITY: begin
        if (tick_c) begin
          state_d    = S_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = '0;
        end
      end

      S_STOP: begin
        if (tick_c) begin
          if (stop_cnt_q != LAST_STOP) begin
            stop_cnt_d = stop_cnt_q + STOP_W'(1);
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign tx_out       = tx_q;
  assign busy_out     = busy_q;
  assign tx_ready_out = ready_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: default, even/odd parity and two-stop variants.
module tb_uart_tx_serializer;

  localparam int BIT_CYC = 26;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       baud;
  logic       v   [4];
  logic [7:0] d   [4];
  logic       tx  [4];
  logic       rdy [4];
  logic       bsy [4];

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  bit  baud_run = 1'b1;
  int  bcnt = 0;
  int  xfer_cnt = 0;
  logic [7:0] xlog [8];

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Transfer monitor on the default instance
  always @(posedge clk_in) begin
    if (v[0] && rdy[0]) begin
      xlog[xfer_cnt % 8] <= d[0];
      xfer_cnt <= xfer_cnt + 1;
    end
  end

  // Baud clock: 26 system cycles, 13 high / 13 low, held low while stalled
  initial begin
    baud = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (baud_run) begin
        bcnt = (bcnt == BIT_CYC - 1) ? 0 : bcnt + 1;
        baud = (bcnt < 13);
      end else begin
        baud = 1'b0;
      end
    end
  end

  uart_tx_serializer u_def (
    .clk_in(clk_in), .rst_n_in(rst_n), .baud_clk_in(baud),
    .tx_data_in(d[0]), .tx_valid_in(v[0]),
    .tx_ready_out(rdy[0]), .tx_out(tx[0]), .busy_out(bsy[0])
  );

  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
    .clk_in(clk_in), .rst_n_in(rst_n), .baud_clk_in(baud),
    .tx_data_in(d[1]), .tx_valid_in(v[1]),
    .tx_ready_out(rdy[1]), .tx_out(tx[1]), .busy_out(bsy[1])
  );

  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
    .clk_in(clk_in), .rst_n_in(rst_n), .baud_clk_in(baud),
    .tx_data_in(d[2]), .tx_valid_in(v[2]),
    .tx_ready_out(rdy[2]), .tx_out(tx[2]), .busy_out(bsy[2])
  );

  uart_tx_serializer #(.STOP_BITS(2)) u_stop2 (
    .clk_in(clk_in), .rst_n_in(rst_n), .baud_clk_in(baud),
    .tx_data_in(d[3]), .tx_valid_in(v[3]),
    .tx_ready_out(rdy[3]), .tx_out(tx[3]), .busy_out(bsy[3])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for the baud clock to go low so the next rise is after the transfer
  task automatic wait_baud_low();
    int t = 0;
    while (!baud && t < 100) begin @(negedge clk_in); t++; end
    while (baud && t < 200) begin @(negedge clk_in); t++; end
    repeat (2) @(negedge clk_in);
  endtask

  task automatic send(input int idx, input logic [7:0] data, input string tag);
    int t = 0;
    while (!rdy[idx] && t < 1000) begin @(negedge clk_in); t++; end
    check_eq({tag, "_ready_before"}, 32'(rdy[idx]), 32'd1);
    d[idx] = data;
    v[idx] = 1'b1;
    @(negedge clk_in);
    v[idx] = 1'b0;
    check_eq({tag, "_ready_after"}, 32'(rdy[idx]), 32'd0);
    check_eq({tag, "_busy_after"}, 32'(bsy[idx]), 32'd1);
  endtask

  // Wait for the start-bit falling edge, noting the first baud rise seen
  task automatic wait_fall(input int idx, input string tag, output int c_fall, output int c_rise);
    logic prev;
    int   t = 0;
    prev   = baud;
    c_rise = -1;
    while (t < 3000) begin
      @(negedge clk_in);
      t++;
      if (c_rise < 0 && baud && !prev) c_rise = cyc;
      prev = baud;
      if (tx[idx] == 1'b0) break;
    end
    check_eq({tag, "_start_seen"}, 32'(tx[idx]), 32'd0);
    c_fall = cyc;
  endtask

  // Sample a frame mid-bit, measure the first low run and the fall-to-ready time
  task automatic capture(input int idx, input int nbits, input string tag,
                         input logic [15:0] exp_bits, input int exp_low,
                         output int c_fall, output int c_rise);
    logic [15:0] bits;
    int  low_run = 0;
    bit  still_low = 1'b1;
    bit  rdy_early = 1'b0;
    int  frame_cyc = -1;
    bits = '0;
    wait_fall(idx, tag, c_fall, c_rise);
    for (int k = 0; k < nbits * BIT_CYC + 100; k++) begin
      if ((k % BIT_CYC) == 13 && (k / BIT_CYC) < nbits) bits[k / BIT_CYC] = tx[idx];
      if (still_low && tx[idx] == 1'b0) low_run++;
      else still_low = 1'b0;
      if (rdy[idx]) begin
        if (k < nbits * BIT_CYC) rdy_early = 1'b1;
        else begin
          frame_cyc = k;
          break;
        end
      end
      @(negedge clk_in);
    end
    check_eq({tag, "_bits"}, 32'(bits), 32'(exp_bits));
    check_eq({tag, "_low_run"}, 32'(low_run), 32'(exp_low));
    check_eq({tag, "_frame_cyc"}, 32'(frame_cyc), 32'(nbits * BIT_CYC));
    check_eq({tag, "_ready_low_in_frame"}, 32'(rdy_early), 32'd0);
  endtask

  initial begin
    int cf, cr, cf2, cr2, base, t;
    bit saw_low, saw_idle;

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b0;
      d[i] = 8'h00;
    end
    repeat (3) @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("reset_tx%0d", i), 32'(tx[i]), 32'd1);
      check_eq($sformatf("reset_ready%0d", i), 32'(rdy[i]), 32'd1);
      check_eq($sformatf("reset_busy%0d", i), 32'(bsy[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // Basic 0xA5 frame with start latency measurement
    wait_baud_low();
    send(0, 8'hA5, "basic");
    capture(0, 10, "basic", 16'h034A, BIT_CYC, cf, cr);
    check_eq("basic_start_latency", 32'((cf - cr) >= 3 && (cf - cr) <= 4), 32'd1);
    check_eq("basic_busy_end", 32'(bsy[0]), 32'd0);

    // Back-to-back words with tx_valid_in held high
    base   = xfer_cnt;
    d[0]   = 8'h3C;
    v[0]   = 1'b1;
    t      = 0;
    while (xfer_cnt == base && t < 200) begin @(negedge clk_in); t++; end
    d[0] = 8'hC3;
    capture(0, 10, "hs1", 16'h0278, 3 * BIT_CYC, cf, cr);
    t = 0;
    while (xfer_cnt < base + 2 && t < 20) begin @(negedge clk_in); t++; end
    v[0] = 1'b0;
    check_eq("hs_second_xfer", 32'(xfer_cnt - base), 32'd2);
    capture(0, 10, "hs2", 16'h0386, BIT_CYC, cf2, cr2);
    check_eq("hs_gap", 32'((cf2 - (cf + 9 * BIT_CYC)) >= BIT_CYC &&
                           (cf2 - (cf + 9 * BIT_CYC)) <= 2 * BIT_CYC), 32'd1);
    repeat (300) @(negedge clk_in);
    check_eq("hs_xfer_total", 32'(xfer_cnt - base), 32'd2);
    check_eq("hs_word0", 32'(xlog[base % 8]), 32'h3C);
    check_eq("hs_word1", 32'(xlog[(base + 1) % 8]), 32'hC3);
    check_eq("hs_idle_line", 32'(tx[0]), 32'd1);

    // Parity variants
    send(1, 8'hA5, "par_even");
    capture(1, 11, "par_even", 16'h054A, BIT_CYC, cf, cr);
    send(2, 8'h01, "par_odd");
    capture(2, 11, "par_odd", 16'h0402, BIT_CYC, cf, cr);

    // Two stop bits
    send(3, 8'h00, "stop2");
    capture(3, 11, "stop2", 16'h0600, 9 * BIT_CYC, cf, cr);

    // Stalled divider
    wait_baud_low();
    baud_run = 1'b0;
    send(0, 8'h5A, "stall");
    saw_low  = 1'b0;
    saw_idle = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_in);
      if (!tx[0]) saw_low = 1'b1;
      if (!bsy[0]) saw_idle = 1'b1;
    end
    check_eq("stall_tx_low", 32'(saw_low), 32'd0);
    check_eq("stall_busy_drop", 32'(saw_idle), 32'd0);
    baud_run = 1'b1;
    capture(0, 10, "stall", 16'h02B4, 2 * BIT_CYC, cf, cr);

    // Reset during data bit 3 of an all-ones frame
    send(0, 8'hFF, "rstmid");
    wait_fall(0, "rstmid", cf, cr);
    repeat (4 * BIT_CYC + 13) @(negedge clk_in);
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    check_eq("rstmid_tx", 32'(tx[0]), 32'd1);
    check_eq("rstmid_ready", 32'(rdy[0]), 32'd1);
    check_eq("rstmid_busy", 32'(bsy[0]), 32'd0);
    saw_low = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_in);
      if (!tx[0] || !rdy[0]) saw_low = 1'b1;
    end
    check_eq("rstmid_abandoned", 32'(saw_low), 32'd0);
    send(0, 8'h00, "after_rst");
    capture(0, 10, "after_rst", 16'h0200, 9 * BIT_CYC, cf, cr);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
